// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter/sequencer with read-modify-write for partial stores
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise LS has fixed priority over IF.
module mem_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [AWIDTH-1:0] ls_addr_i,
  input  logic [DWIDTH-1:0] ls_wdata_i,
  input  logic [3:0]        ls_be_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DWIDTH-1:0] ls_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              last_ls_q, last_ls_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DWIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic [AWIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [DWIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
  logic [DWIDTH-1:0] rmw_old_q, rmw_old_d;
  logic [3:0]        rmw_be_q, rmw_be_d;
  logic [DWIDTH-1:0] merged;
  logic              ls_pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On conflict, LS wins only if IF was the last port granted.
  assign ls_pick = ls_req_i && (!if_req_i || !last_ls_q);
`else
  assign ls_pick = ls_req_i;
`endif

  always_comb begin
    merged = '0;
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = rmw_be_q[k] ? rmw_wdata_q[8*k +: 8] : rmw_old_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d        = state_q;
    last_ls_d      = last_ls_q;
    if_gnt_o       = 1'b0;
    ls_gnt_o       = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    if_rvalid_d    = 1'b0;
    if_rdata_d     = if_rdata_q;
    ls_rvalid_d    = 1'b0;
    ls_rdata_d     = ls_rdata_q;
    rmw_addr_d     = rmw_addr_q;
    rmw_wdata_d    = rmw_wdata_q;
    rmw_old_d      = rmw_old_q;
    rmw_be_d       = rmw_be_q;

    if (state_q == RMW) begin
      mem_write_en_o = 1'b1;
      mem_addr_o     = rmw_addr_q;
      mem_data_o     = merged;
      ls_rvalid_d    = 1'b1;
      ls_rdata_d     = '0;
      state_d        = IDLE;
    end else if (ls_pick) begin
      ls_gnt_o   = 1'b1;
      last_ls_d  = 1'b1;
      mem_addr_o = ls_addr_i;
      if (!ls_we_i) begin
        mem_read_en_o = 1'b1;
        ls_rvalid_d   = 1'b1;
        ls_rdata_d    = mem_data_i;
      end else if (ls_be_i == 4'b1111) begin
        mem_write_en_o = 1'b1;
        mem_data_o     = ls_wdata_i;
        ls_rvalid_d    = 1'b1;
        ls_rdata_d     = '0;
      end else if (ls_be_i == 4'b0000) begin
        mem_addr_o  = '0;
        ls_rvalid_d = 1'b1;
        ls_rdata_d  = '0;
      end else begin
        // Partial store: fetch the old word now, write the merge next cycle.
        mem_read_en_o = 1'b1;
        rmw_addr_d    = ls_addr_i;
        rmw_wdata_d   = ls_wdata_i;
        rmw_old_d     = mem_data_i;
        rmw_be_d      = ls_be_i;
        state_d       = RMW;
      end
    end else if (if_req_i) begin
      if_gnt_o      = 1'b1;
      last_ls_d     = 1'b0;
      mem_read_en_o = 1'b1;
      mem_addr_o    = if_addr_i;
      if_rvalid_d   = 1'b1;
      if_rdata_d    = mem_data_i;
    end

    if (rst) begin
      if_gnt_o       = 1'b0;
      ls_gnt_o       = 1'b0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_addr_o     = '0;
      mem_data_o     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_ls_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_old_q   <= '0;
      rmw_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_old_q   <= rmw_old_d;
      rmw_be_q    <= rmw_be_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with an in-bench reference model
// Honours MEM_ARB_ROUND_ROBIN_EN for conflict expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_gnt_o, if_rvalid_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i, ls_rdata_o;
  logic [3:0]    ls_be_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          mem_read_en_o, mem_write_en_o;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] preload(input int i);
    if (i == 0) return 32'hDEADBEEF;
    if (i == 8) return 32'hAABBCCDD;
    return 32'h1000_0000 + i * 32'h0101;
  endfunction

  // Memory behind the arbiter: 64 words at 0x01000000, combinational read.
  logic [31:0] env_mem [0:63];
  logic        init_mem;
  assign mem_data_i = env_mem[mem_addr_o[7:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= preload(i);
    end else if (mem_write_en_o) begin
      env_mem[mem_addr_o[7:2]] <= mem_data_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    bit          is_ls;
    logic [31:0] data;
  } resp_t;

  function automatic resp_t mk(input int due, input bit is_ls, input logic [31:0] data);
    resp_t r;
    r.due = due; r.is_ls = is_ls; r.data = data;
    return r;
  endfunction

  resp_t       pend[$];
  resp_t       keep[$];
  logic [31:0] ref_mem [0:63];
  int          cyc = 0;
  bit          rmw_busy = 1'b0;
  logic [31:0] rmw_a, rmw_w;
  bit          last_was_ls = 1'b0;

  // Reference model: per-cycle expectations from the arbitration/sequencing rules.
  always @(negedge clk) begin : model
    bit          e_ifv, e_lsv, g_if, g_ls, e_re, e_we;
    logic [31:0] e_ifd, e_lsd, e_a, e_d, w;
    if (cyc == 0) for (int i = 0; i < 64; i++) ref_mem[i] = preload(i);
    e_ifv = 1'b0; e_lsv = 1'b0; e_ifd = '0; e_lsd = '0;
    keep.delete();
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].is_ls) begin e_lsv = 1'b1; e_lsd = pend[i].data; end
        else begin e_ifv = 1'b1; e_ifd = pend[i].data; end
      end else if (pend[i].due > cyc) begin
        keep.push_back(pend[i]);
      end
    end
    pend = keep;
    chk("if_rvalid", {31'b0, if_rvalid_o}, {31'b0, e_ifv});
    chk("ls_rvalid", {31'b0, ls_rvalid_o}, {31'b0, e_lsv});
    if (e_ifv) chk("if_rdata", if_rdata_o, e_ifd);
    if (e_lsv) chk("ls_rdata", ls_rdata_o, e_lsd);

    g_if = 1'b0; g_ls = 1'b0; e_re = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0;
    if (rst) begin
      rmw_busy = 1'b0;
      last_was_ls = 1'b0;
      pend.delete();
    end else if (rmw_busy) begin
      e_we = 1'b1; e_a = rmw_a; e_d = rmw_w;
      ref_mem[rmw_a[7:2]] = rmw_w;
      pend.push_back(mk(cyc + 1, 1'b1, 32'h0));
      rmw_busy = 1'b0;
    end else begin
      if (ls_req_i && if_req_i) g_ls = RR ? !last_was_ls : 1'b1;
      else g_ls = ls_req_i;
      g_if = if_req_i && !g_ls;
      if (g_if) begin
        last_was_ls = 1'b0;
        e_re = 1'b1; e_a = if_addr_i;
        pend.push_back(mk(cyc + 1, 1'b0, ref_mem[if_addr_i[7:2]]));
      end
      if (g_ls) begin
        last_was_ls = 1'b1;
        e_a = ls_addr_i;
        if (!ls_we_i) begin
          e_re = 1'b1;
          pend.push_back(mk(cyc + 1, 1'b1, ref_mem[ls_addr_i[7:2]]));
        end else if ($countones(ls_be_i) == 4) begin
          e_we = 1'b1; e_d = ls_wdata_i;
          ref_mem[ls_addr_i[7:2]] = ls_wdata_i;
          pend.push_back(mk(cyc + 1, 1'b1, 32'h0));
        end else if ($countones(ls_be_i) == 0) begin
          e_a = '0;
          pend.push_back(mk(cyc + 1, 1'b1, 32'h0));
        end else begin
          e_re = 1'b1;
          w = ref_mem[ls_addr_i[7:2]];
          for (int k = 0; k < 4; k++) if (ls_be_i[k]) w[8*k +: 8] = ls_wdata_i[8*k +: 8];
          rmw_busy = 1'b1; rmw_a = ls_addr_i; rmw_w = w;
        end
      end
    end
    chk("if_gnt", {31'b0, if_gnt_o}, {31'b0, g_if});
    chk("ls_gnt", {31'b0, ls_gnt_o}, {31'b0, g_ls});
    chk("mem_read_en", {31'b0, mem_read_en_o}, {31'b0, e_re});
    chk("mem_write_en", {31'b0, mem_write_en_o}, {31'b0, e_we});
    if (!rst) begin
      chk("mem_addr", mem_addr_o, e_a);
      chk("mem_data", mem_data_o, e_d);
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit ls);
    int n;
    n = 0;
    while (!(ls ? ls_gnt_o : if_gnt_o) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) chk("gnt_timeout", {31'b0, ls ? ls_gnt_o : if_gnt_o}, 32'h1);
  endtask

  task automatic ls_issue(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    ls_we_i = we; ls_addr_i = a; ls_wdata_i = wd; ls_be_i = be; ls_req_i = 1'b1;
    #1;
    wait_gnt(1'b1);
  endtask

  initial begin
    rst = 1'b1; init_mem = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
    step(); init_mem = 1'b0;
    step();
    chk("reset_if_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    chk("reset_ls_rdata", ls_rdata_o, 32'h0);
    step(); rst = 1'b0;

    // Fetch read
    if_addr_i = 32'h0100_0000; if_req_i = 1'b1; #1;
    wait_gnt(1'b0);
    chk("t1_read_en", {31'b0, mem_read_en_o}, 32'h1);
    step(); if_req_i = 1'b0; #1;
    chk("t1_if_rvalid", {31'b0, if_rvalid_o}, 32'h1);
    chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);

    // Full store then load
    ls_issue(1'b1, 32'h0100_0010, 32'h1234_5678, 4'b1111);
    chk("t2_write_en", {31'b0, mem_write_en_o}, 32'h1);
    step(); ls_req_i = 1'b0; #1;
    chk("t2_ack", {31'b0, ls_rvalid_o}, 32'h1);
    chk("t2_ack_rdata", ls_rdata_o, 32'h0);
    ls_issue(1'b0, 32'h0100_0010, 32'h0, 4'b0000);
    step(); ls_req_i = 1'b0; #1;
    chk("t2_load", ls_rdata_o, 32'h1234_5678);

    // Reset during the RMW write cycle
    ls_issue(1'b1, 32'h0100_0020, 32'h0000_1100, 4'b0010);
    chk("t5_read_en", {31'b0, mem_read_en_o}, 32'h1);
    step(); ls_req_i = 1'b0; rst = 1'b1; #1;
    chk("t5_write_en", {31'b0, mem_write_en_o}, 32'h0);
    step(); rst = 1'b0; #1;
    chk("t5_no_ack", {31'b0, ls_rvalid_o}, 32'h0);
    chk("t5_mem_kept", env_mem[8], 32'hAABBCCDD);
    if_addr_i = 32'h0100_0004; if_req_i = 1'b1; #1;
    chk("t5_idle_gnt", {31'b0, if_gnt_o}, 32'h1);
    step(); if_req_i = 1'b0; #1;
    chk("t5_if_rdata", if_rdata_o, preload(1));

    // Partial store via RMW; fetch waiting in the write cycle must not be granted
    ls_issue(1'b1, 32'h0100_0020, 32'h0000_1100, 4'b0010);
    chk("t3_read_en", {31'b0, mem_read_en_o}, 32'h1);
    step(); ls_req_i = 1'b0; if_addr_i = 32'h0100_0000; if_req_i = 1'b1; #1;
    chk("t3_write_en", {31'b0, mem_write_en_o}, 32'h1);
    chk("t3_merged", mem_data_o, 32'hAABB11DD);
    chk("t3_no_if_gnt", {31'b0, if_gnt_o}, 32'h0);
    step(); #1;
    chk("t3_ack", {31'b0, ls_rvalid_o}, 32'h1);
    chk("t3_if_gnt_after", {31'b0, if_gnt_o}, 32'h1);
    step(); if_req_i = 1'b0;
    ls_issue(1'b0, 32'h0100_0020, 32'h0, 4'b0000);
    step(); ls_req_i = 1'b0; #1;
    chk("t3_reload", ls_rdata_o, 32'hAABB11DD);

    // Empty byte-enable store
    ls_issue(1'b1, 32'h0100_0030, 32'hFFFF_FFFF, 4'b0000);
    chk("t6_no_enable", {30'b0, mem_read_en_o, mem_write_en_o}, 32'h0);
    step(); ls_req_i = 1'b0; #1;
    chk("t6_ack", {31'b0, ls_rvalid_o}, 32'h1);
    chk("t6_mem_kept", env_mem[12], preload(12));

    // Conflict for 4 cycles, starting from a freshly reset pointer
    step(); rst = 1'b1; step(); rst = 1'b0;
    ls_we_i = 1'b0; ls_addr_i = 32'h0100_0010; ls_req_i = 1'b1;
    if_addr_i = 32'h0100_0000; if_req_i = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_ls_gnt", {31'b0, ls_gnt_o}, {31'b0, (RR ? (k % 2 == 0) : 1'b1)});
      chk("t4_if_gnt", {31'b0, if_gnt_o}, {31'b0, (RR ? (k % 2 == 1) : 1'b0)});
      @(posedge clk); #1;
      if (k == 3) begin ls_req_i = 1'b0; if_req_i = 1'b0; end
      #1;
    end

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
